dpram_port_arbiter: RTL and testbench
=====================================

Name: dpram_port_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one port of the team's true dual-port RAM (clk1 side) among NUM_REQ requesters.
- Accepts read/write requests through a valid/ready handshake and drives the RAM port strobes, address and write data.
- Captures the RAM's registered read data and returns it with the requester ID.
- Sits between requester logic and port 1 of the dual-port RAM. Port 2 is untouched.

Parameters:
- NUM_REQ, 4: number of requesters, 2..8.
- ADDR_WIDTH, 4: RAM address width.
- DATA_WIDTH, 4: RAM data width.
- ID_WIDTH, $clog2(NUM_REQ): width of rsp_id (localparam).

Ports:
- clk1  in  1  clock
- reset  in  1  synchronous, active-high
- req_valid  in  NUM_REQ  per-requester request valid
- req_we  in  NUM_REQ  1 = write, 0 = read
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i uses slice i
- req_wdata  in  NUM_REQ*DATA_WIDTH  packed write data
- req_ready  out  NUM_REQ  one-hot grant/accept pulse
- rsp_valid  out  1  response valid, 1-cycle pulse
- rsp_id  out  ID_WIDTH  requester index of the response
- rsp_rdata  out  DATA_WIDTH  read data
- rsp_is_wr  out  1  response is a write ack (0 unless DPRAM_ARB_WRITE_ACK_EN)
- ram_we  out  1  to RAM we1
- ram_re  out  1  to RAM re1
- ram_addr  out  ADDR_WIDTH  to RAM addr1
- ram_din  out  DATA_WIDTH  to RAM din1
- ram_dout  in  DATA_WIDTH  from RAM dout1 (registered in the RAM, 1-cycle latency after re1)

Behaviour:
- Reset: reset, synchronous, active-high; clock clk1. On reset:
  - all outputs 0;
  - FSM = IDLE;
  - round-robin pointer = 0.
- Reset mid-operation aborts any in-flight transaction. No response is issued, and the requester must re-request.
- FSM states: IDLE, ISSUE, CAPTURE, RESP.
- IDLE:
  - If any req_valid is set, the winner is the first set bit searching from the pointer upward, wrapping modulo NUM_REQ.
  - req_ready[winner] = 1 for exactly this cycle (combinational from state and req_valid).
  - The winner's we/addr/wdata and index are registered.
  - Pointer <= (winner+1) mod NUM_REQ.
  - Next state = ISSUE.
  - If no req_valid, stay in IDLE and keep the pointer.
- ISSUE:
  - ram_addr/ram_din are driven from the latched request.
  - Write: ram_we = 1, ram_re = 0.
  - Read: ram_re = 1, ram_we = 0.
  - Strobes are high for exactly this one cycle.
  - Next state: write → IDLE (or RESP with ack, see feature); read → CAPTURE.
- CAPTURE: ram_dout is valid in this cycle. rsp_rdata <= ram_dout; next state = RESP.
- RESP: rsp_valid = 1 with rsp_id = latched index for one cycle; next state = IDLE. There is no response backpressure.
- Latency:
  - Read: grant at cycle N, ram_re at N+1, rsp_valid at N+3; next grant possible at N+4.
  - Write: grant at N, ram_we at N+1; next grant at N+2.
- rsp_rdata holds its last captured value until the next read capture.
- Requesters hold valid/we/addr/wdata stable until ready. Dropping valid before ready is permitted (no grant is given).
- Only one grant is ever outstanding; the FSM serialises all traffic.
- A requester re-asserting immediately after its grant has lowest priority next round. Fairness bound: every valid request is granted within NUM_REQ arbitration rounds.
- Pointer wrap: after winner NUM_REQ-1, the pointer returns to 0.
- Outside ISSUE, ram_we, ram_re, ram_addr and ram_din are 0.

Optional Feature:
- DPRAM_ARB_WRITE_ACK_EN defined:
  - A write proceeds ISSUE → RESP, giving rsp_valid at N+2 with rsp_is_wr = 1, rsp_id = writer and rsp_rdata unchanged.
  - The next grant is at N+3.
- Undefined: writes produce no response; rsp_is_wr is tied to 0; write-to-grant spacing is 2 cycles.

Decomposition:
- Package dpram_arb_pkg holds:
  - the state enum typedef arb_state_t (IDLE, ISSUE, CAPTURE, RESP);
  - default width localparams.
- Sub-module dpram_rr_pick: combinational rotating-priority picker taking req vector and pointer, returning one-hot grant, index and any_req. Pointer register stays in the parent.

Test Plan:
- Reset, then req_valid = 4'b0001, we = 1, addr 3, wdata 4'hA → req_ready = 0001 for 1 cycle, ram_we = 1 with addr 3/din A next cycle, no rsp_valid.
- Write 4'h5 to addr 7 from req 2, then read addr 7 from req 1 → ram_re at grant+1, rsp_valid at grant+3 with rsp_id = 1 and rsp_rdata = 4'h5.
- All four requesters reading continuously from pointer 0 → grant order 0,1,2,3,0 with grants spaced 4 cycles; rsp_id follows the same order.
- Pointer at 3 with req_valid = 4'b1001 → grant 3 then 0; pointer wraps to 0 then 1.
- Reset asserted during CAPTURE of a read → no rsp_valid, all outputs 0 next cycle, first grant afterwards goes to the lowest-index valid requester.
- DPRAM_ARB_WRITE_ACK_EN build, write from req 3 → rsp_valid with rsp_is_wr = 1 and rsp_id = 3 at grant+2.

Source files
------------

// File: rtl/dpram_arb_pkg.sv
// Shared types and default widths for the dual-port RAM port-1 arbiter.
package dpram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    CAPTURE,
    RESP
  } arb_state_t;

  localparam int DEF_NUM_REQ    = 4;
  localparam int DEF_ADDR_WIDTH = 4;
  localparam int DEF_DATA_WIDTH = 4;

endpackage

// File: rtl/dpram_rr_pick.sv
// Combinational rotating-priority picker: first set request at or above ptr,
// wrapping modulo NUM_REQ. The pointer register lives in the parent.
module dpram_rr_pick #(
  parameter int NUM_REQ  = 4,
  parameter int ID_WIDTH = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]  req,
  input  logic [ID_WIDTH-1:0] ptr,
  output logic [NUM_REQ-1:0]  grant,
  output logic [ID_WIDTH-1:0] idx,
  output logic                any_req
);

  always_comb begin
    int pos;
    pos     = 0;
    idx     = '0;
    any_req = 1'b0;
    // Walk from the farthest slot back to ptr so the closest set bit is written last.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      pos = (int'(ptr) + k) % NUM_REQ;
      if (req[pos]) begin
        idx     = ID_WIDTH'(pos);
        any_req = 1'b1;
      end
    end
    grant = any_req ? (NUM_REQ'(1) << idx) : '0;
  end

endmodule

// File: rtl/dpram_port_arbiter.sv
// Round-robin arbiter/sequencer sharing RAM port 1 among NUM_REQ requesters.
// Build option: DPRAM_ARB_WRITE_ACK_EN adds a response (rsp_is_wr = 1) for writes.
module dpram_port_arbiter
  import dpram_arb_pkg::*;
#(
  parameter int  NUM_REQ    = DEF_NUM_REQ,
  parameter int  ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int  DATA_WIDTH = DEF_DATA_WIDTH,
  localparam int ID_WIDTH   = $clog2(NUM_REQ)
) (
  input  logic                          clk1,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          rsp_valid,
  output logic [ID_WIDTH-1:0]           rsp_id,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic                          rsp_is_wr,
  output logic                          ram_we,
  output logic                          ram_re,
  output logic [ADDR_WIDTH-1:0]         ram_addr,
  output logic [DATA_WIDTH-1:0]         ram_din,
  input  logic [DATA_WIDTH-1:0]         ram_dout
);

  arb_state_t state, state_next;

  logic [ID_WIDTH-1:0]   ptr;
  logic [ID_WIDTH-1:0]   cur_id;
  logic                  cur_we;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [DATA_WIDTH-1:0] cur_wdata;
  logic [DATA_WIDTH-1:0] rdata;

  logic [NUM_REQ-1:0]    pick_grant;
  logic [ID_WIDTH-1:0]   pick_idx;
  logic                  pick_any;

  logic [ADDR_WIDTH-1:0] addr_arr  [NUM_REQ];
  logic [DATA_WIDTH-1:0] wdata_arr [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
    assign addr_arr[gi]  = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_arr[gi] = req_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  dpram_rr_pick #(
    .NUM_REQ  (NUM_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_pick (
    .req     (req_valid),
    .ptr     (ptr),
    .grant   (pick_grant),
    .idx     (pick_idx),
    .any_req (pick_any)
  );

  always_ff @(posedge clk1) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    req_ready  = '0;
    rsp_valid  = 1'b0;
    rsp_id     = '0;
    rsp_is_wr  = 1'b0;
    ram_we     = 1'b0;
    ram_re     = 1'b0;
    ram_addr   = '0;
    ram_din    = '0;
    case (state)
      IDLE: begin
        if (pick_any) begin
          req_ready  = pick_grant;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        ram_addr = cur_addr;
        ram_din  = cur_wdata;
        if (cur_we) begin
          ram_we = 1'b1;
`ifdef DPRAM_ARB_WRITE_ACK_EN
          state_next = RESP;
`else
          state_next = IDLE;
`endif
        end else begin
          ram_re     = 1'b1;
          state_next = CAPTURE;
        end
      end
      CAPTURE: state_next = RESP;
      RESP: begin
        rsp_valid = 1'b1;
        rsp_id    = cur_id;
`ifdef DPRAM_ARB_WRITE_ACK_EN
        rsp_is_wr = cur_we;
`endif
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // Keep every output quiet while reset is held, whatever state we were in.
    if (reset) begin
      req_ready = '0;
      rsp_valid = 1'b0;
      rsp_id    = '0;
      rsp_is_wr = 1'b0;
      ram_we    = 1'b0;
      ram_re    = 1'b0;
      ram_addr  = '0;
      ram_din   = '0;
    end
  end

  always_ff @(posedge clk1) begin
    if (reset) begin
      ptr       <= '0;
      cur_id    <= '0;
      cur_we    <= 1'b0;
      cur_addr  <= '0;
      cur_wdata <= '0;
      rdata     <= '0;
    end else begin
      if (state == IDLE && pick_any) begin
        cur_id    <= pick_idx;
        cur_we    <= req_we[pick_idx];
        cur_addr  <= addr_arr[pick_idx];
        cur_wdata <= wdata_arr[pick_idx];
        ptr       <= (pick_idx == ID_WIDTH'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
      end
      if (state == CAPTURE) rdata <= ram_dout;
    end
  end

  assign rsp_rdata = rdata;

endmodule

// File: tb/tb_dpram_port_arbiter.sv
// Scoreboard bench for dpram_port_arbiter: a cycle-level round-robin model predicts
// grants, RAM strobes and responses; a separate monitor pops and compares them.
module tb_dpram_port_arbiter;

  localparam int NUM_REQ = 4;
  localparam int AW      = 4;
  localparam int DW      = 4;
  localparam int IDW     = $clog2(NUM_REQ);
`ifdef DPRAM_ARB_WRITE_ACK_EN
  localparam bit ACK = 1'b1;
`else
  localparam bit ACK = 1'b0;
`endif

  logic                   clk1 = 1'b0;
  logic                   reset = 1'b1;
  logic [NUM_REQ-1:0]     req_valid = '0;
  logic [NUM_REQ-1:0]     req_we = '0;
  logic [NUM_REQ*AW-1:0]  req_addr = '0;
  logic [NUM_REQ*DW-1:0]  req_wdata = '0;
  logic [NUM_REQ-1:0]     req_ready;
  logic                   rsp_valid;
  logic [IDW-1:0]         rsp_id;
  logic [DW-1:0]          rsp_rdata;
  logic                   rsp_is_wr;
  logic                   ram_we;
  logic                   ram_re;
  logic [AW-1:0]          ram_addr;
  logic [DW-1:0]          ram_din;
  logic [DW-1:0]          ram_dout;

  dpram_port_arbiter #(
    .NUM_REQ    (NUM_REQ),
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW)
  ) dut (
    .clk1      (clk1),
    .reset     (reset),
    .req_valid (req_valid),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_rdata (rsp_rdata),
    .rsp_is_wr (rsp_is_wr),
    .ram_we    (ram_we),
    .ram_re    (ram_re),
    .ram_addr  (ram_addr),
    .ram_din   (ram_din),
    .ram_dout  (ram_dout)
  );

  always #5 clk1 = ~clk1;

  // Port-1 side of the RAM: registered read, one cycle after re.
  logic [DW-1:0] ram_mem [1<<AW] = '{default: '0};
  always @(posedge clk1) begin
    if (ram_we) ram_mem[ram_addr] <= ram_din;
    if (ram_re) ram_dout <= ram_mem[ram_addr];
  end

  int cyc = 0;
  always @(posedge clk1) cyc <= cyc + 1;

  typedef struct { int cyc; bit we; logic [AW-1:0] addr; logic [DW-1:0] din; } stb_t;
  typedef struct { int cyc; int id; logic [DW-1:0] data; bit is_wr; } rsp_t;

  stb_t stb_q[$];
  rsp_t rsp_q[$];
  stb_t mon_s;
  rsp_t mon_r;

  int            checks = 0;
  int            failures = 0;
  int            ptr_m = 0;
  int            free_cyc = 0;
  logic [DW-1:0] last_rd = '0;
  logic [DW-1:0] mem_m [1<<AW] = '{default: '0};
  logic [NUM_REQ-1:0] last_ready = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  // Reference model, evaluated once per cycle on the falling edge.
  task automatic model_step();
    logic [NUM_REQ-1:0] exp_ready;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    bit w;
    int win;
    exp_ready = '0;
    win = -1;
    if (reset) begin
      ptr_m = 0;
      free_cyc = 0;
      last_rd = '0;
      rsp_q.delete();
      stb_q.delete();
      check("reset_outputs", {ram_we, ram_re, ram_addr, ram_din, rsp_valid, rsp_id, rsp_is_wr}, '0);
    end else if (cyc >= free_cyc) begin
      for (int k = 0; k < NUM_REQ; k++)
        if (win < 0 && req_valid[(ptr_m + k) % NUM_REQ]) win = (ptr_m + k) % NUM_REQ;
      if (win >= 0) begin
        a = req_addr[win*AW +: AW];
        d = req_wdata[win*DW +: DW];
        w = req_we[win];
        exp_ready[win] = 1'b1;
        stb_q.push_back('{cyc + 1, w, a, d});
        if (w) begin
          mem_m[a] = d;
          if (ACK) rsp_q.push_back('{cyc + 2, win, last_rd, 1'b1});
          free_cyc = cyc + 2 + int'(ACK);
        end else begin
          last_rd = mem_m[a];
          rsp_q.push_back('{cyc + 3, win, mem_m[a], 1'b0});
          free_cyc = cyc + 4;
        end
        ptr_m = (win + 1) % NUM_REQ;
        $display("grant cyc=%0d req=%0d %s addr=%h data=%h", cyc, win, w ? "wr" : "rd", a,
                 w ? d : mem_m[a]);
      end
    end
    check("req_ready", req_ready, exp_ready);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a strobe or response.
  always @(negedge clk1) begin
    if (!reset) begin
      if (rsp_valid) begin
        if (rsp_q.size() == 0) check("rsp_unexpected", rsp_valid, 1'b0);
        else begin
          mon_r = rsp_q.pop_front();
          check("rsp_cycle", cyc, mon_r.cyc);
          check("rsp_id", rsp_id, mon_r.id);
          check("rsp_rdata", rsp_rdata, mon_r.data);
          check("rsp_is_wr", rsp_is_wr, mon_r.is_wr);
        end
      end else if (rsp_q.size() != 0 && rsp_q[0].cyc <= cyc) begin
        check("rsp_missing", rsp_valid, 1'b1);
        rsp_q.delete(0);
      end
      if (ram_we || ram_re) begin
        if (stb_q.size() == 0) check("ram_strobe_unexpected", ram_we | ram_re, 1'b0);
        else begin
          mon_s = stb_q.pop_front();
          check("ram_cycle", cyc, mon_s.cyc);
          check("ram_we", ram_we, mon_s.we);
          check("ram_re", ram_re, !mon_s.we);
          check("ram_addr", ram_addr, mon_s.addr);
          check("ram_din", ram_din, mon_s.din);
        end
      end else begin
        check("ram_bus_idle", {ram_addr, ram_din}, '0);
        if (stb_q.size() != 0 && stb_q[0].cyc <= cyc) begin
          check("ram_strobe_missing", ram_we | ram_re, 1'b1);
          stb_q.delete(0);
        end
      end
    end
  end

  task automatic to_drive();
    @(posedge clk1);
    #1;
  endtask

  task automatic settle();
    @(negedge clk1);
    model_step();
    last_ready = req_ready;
  endtask

  task automatic set_txn(input int i, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_we[i] = we;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  // Raise every requester in mask, drop each as it is granted, bounded wait.
  task automatic burst(input logic [NUM_REQ-1:0] mask);
    logic [NUM_REQ-1:0] left;
    int n;
    left = mask;
    n = 0;
    to_drive();
    req_valid = mask;
    settle();
    left &= ~last_ready;
    while (left != 0 && n < 40) begin
      to_drive();
      req_valid &= ~last_ready;
      settle();
      left &= ~last_ready;
      n++;
    end
    check("grant_timeout", left, '0);
    to_drive();
    req_valid = '0;
    settle();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
    $fatal(1);
  end

  initial begin
    int n;
    for (int i = 0; i < NUM_REQ; i++) set_txn(i, 1'b0, AW'(i), DW'(i));
    req_valid = '1;
    repeat (3) begin
      to_drive();
      settle();
    end
    check("reset_rdata", rsp_rdata, '0);
    to_drive();
    reset = 1'b0;
    req_valid = '0;
    settle();

    // Directed traffic: lone write, write then read-back, wrap from pointer 3.
    set_txn(0, 1'b1, 4'd3, 4'hA);
    burst(4'b0001);
    set_txn(2, 1'b1, 4'd7, 4'h5);
    burst(4'b0100);
    set_txn(1, 1'b0, 4'd7, 4'h0);
    burst(4'b0010);
    set_txn(2, 1'b0, 4'd3, 4'h0);
    burst(4'b0100);
    set_txn(0, 1'b0, 4'd7, 4'h1);
    set_txn(3, 1'b0, 4'd3, 4'h2);
    burst(4'b1001);
    for (int i = 0; i < NUM_REQ; i++) set_txn(i, 1'b0, AW'(3 + i), DW'(i));
    burst(4'b1111);
    burst(4'b1111);

    // Abort a read in CAPTURE with reset; afterwards req0 must win over req3.
    set_txn(1, 1'b0, 4'd7, 4'h0);
    to_drive();
    req_valid = 4'b0010;
    settle();
    n = 0;
    while (!last_ready[1] && n < 20) begin
      to_drive();
      settle();
      n++;
    end
    check("abort_setup_grant", last_ready[1], 1'b1);
    set_txn(0, 1'b0, 4'd3, 4'h0);
    set_txn(3, 1'b0, 4'd7, 4'h0);
    to_drive();
    req_valid = 4'b1001;
    settle();
    to_drive();
    reset = 1'b1;
    settle();
    to_drive();
    settle();
    check("abort_rdata_cleared", rsp_rdata, '0);
    to_drive();
    reset = 1'b0;
    settle();
    check("abort_first_grant", req_ready, 4'b0001);
    to_drive();
    req_valid = '0;
    settle();

    // Randomised traffic with drops and immediate re-requests.
    for (int c = 0; c < 1500; c++) begin
      to_drive();
      for (int i = 0; i < NUM_REQ; i++) begin
        if (last_ready[i]) begin
          req_valid[i] = ($urandom_range(0, 2) != 0);
          set_txn(i, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), DW'($urandom));
        end else if (req_valid[i] && $urandom_range(0, 29) == 0) begin
          req_valid[i] = 1'b0;
        end else if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
          req_valid[i] = 1'b1;
          set_txn(i, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), DW'($urandom));
        end
      end
      settle();
    end

    to_drive();
    req_valid = '0;
    settle();
    repeat (8) begin
      to_drive();
      settle();
    end
    check("scoreboard_drained", rsp_q.size() + stb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
